// File: rtl/eth_video_line_rx.sv
// GMII receiver that parses Ethernet/IPv4/UDP video-line packets into a pixel stream.
// Optional ETH_VIDEO_RX_PORT_FILTER_EN: drop UDP packets whose destination port is not UDP_PORT.
module eth_video_line_rx #(
  parameter logic [15:0] UDP_PORT   = 16'd8080,
  parameter logic [15:0] MAX_PIXELS = 16'd1920
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_dv,
  output logic [23:0] pixel_data,
  output logic        pixel_de,
  output logic [15:0] line_number,
  output logic        line_sync,
  output logic        frame_sync,
  output logic        line_done,
  output logic        line_err,
  output logic [15:0] drop_cnt
);

  typedef enum logic [2:0] {
    StIdle, StPreamble, StEthHdr, StIpHdr, StUdpHdr, StVidHdr, StPixel, StDrop
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [23:0] sh_q, sh_d;
  logic [15:0] pix_total_q, pix_total_d;
  logic [15:0] pix_cnt_q, pix_cnt_d;
  logic [1:0]  phase_q, phase_d;
  logic        wait_q, wait_d;
  logic [23:0] pixel_data_q, pixel_data_d;
  logic [15:0] line_number_q, line_number_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        pixel_de_q, pixel_de_d, line_sync_q, line_sync_d, frame_sync_q, frame_sync_d;
  logic        line_done_q, line_done_d, line_err_q, line_err_d;
  logic        drop_inc;
  logic [15:0] word;

  // Previous byte concatenated with the current one: a big-endian 16-bit field ending now.
  assign word = {sh_q[7:0], gmii_rxd};

`ifndef ETH_VIDEO_RX_PORT_FILTER_EN
  logic unused_udp_port;
  assign unused_udp_port = ^UDP_PORT;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + 16'd1;
    sh_d          = gmii_rx_dv ? {sh_q[15:0], gmii_rxd} : sh_q;
    pix_total_d   = pix_total_q;
    pix_cnt_d     = pix_cnt_q;
    phase_d       = phase_q;
    wait_d        = wait_q;
    pixel_data_d  = pixel_data_q;
    line_number_d = line_number_q;
    pixel_de_d    = 1'b0;
    line_sync_d   = 1'b0;
    frame_sync_d  = 1'b0;
    line_done_d   = 1'b0;
    line_err_d    = 1'b0;
    drop_inc      = 1'b0;

    unique case (state_q)
      StIdle: begin
        // After reset, wait for the interrupted packet to end before looking for a new one.
        if (wait_q) begin
          if (!gmii_rx_dv) wait_d = 1'b0;
        end else if (gmii_rx_dv) begin
          state_d = StPreamble;
        end
      end
      StPreamble: begin
        if (!gmii_rx_dv) begin
          drop_inc = 1'b1;
          state_d  = StIdle;
        end else if (gmii_rxd == 8'hD5) begin
          state_d = StEthHdr;
        end else if (gmii_rxd != 8'h55) begin
          drop_inc = 1'b1;
          state_d  = StDrop;
        end
      end
      StEthHdr: begin
        if (!gmii_rx_dv) begin
          drop_inc = 1'b1;
          state_d  = StIdle;
        end else if ((cnt_q == 16'd12 && gmii_rxd != 8'h08) ||
                     (cnt_q == 16'd13 && gmii_rxd != 8'h00)) begin
          drop_inc = 1'b1;
          state_d  = StDrop;
        end else if (cnt_q == 16'd13) begin
          state_d = StIpHdr;
        end
      end
      StIpHdr: begin
        if (!gmii_rx_dv) begin
          drop_inc = 1'b1;
          state_d  = StIdle;
        end else if ((cnt_q == 16'd0 && gmii_rxd != 8'h45) ||
                     (cnt_q == 16'd9 && gmii_rxd != 8'h11)) begin
          drop_inc = 1'b1;
          state_d  = StDrop;
        end else if (cnt_q == 16'd19) begin
          state_d = StUdpHdr;
        end
      end
      StUdpHdr: begin
        if (!gmii_rx_dv) begin
          drop_inc = 1'b1;
          state_d  = StIdle;
`ifdef ETH_VIDEO_RX_PORT_FILTER_EN
        end else if (cnt_q == 16'd3 && word != UDP_PORT) begin
          drop_inc = 1'b1;
          state_d  = StDrop;
`endif
        end else if (cnt_q == 16'd7) begin
          state_d = StVidHdr;
        end
      end
      StVidHdr: begin
        if (!gmii_rx_dv) begin
          drop_inc = 1'b1;
          state_d  = StIdle;
        end else if (cnt_q == 16'd3) begin
          if (word == 16'd0 || word > MAX_PIXELS) begin
            drop_inc = 1'b1;
            state_d  = StDrop;
          end else begin
            line_number_d = sh_q[23:8];
            line_sync_d   = 1'b1;
            frame_sync_d  = (sh_q[23:8] == 16'd0);
            pix_total_d   = word;
            pix_cnt_d     = 16'd0;
            phase_d       = 2'd0;
            state_d       = StPixel;
          end
        end
      end
      StPixel: begin
        if (!gmii_rx_dv) begin
          line_err_d = 1'b1;
          drop_inc   = 1'b1;
          state_d    = StIdle;
        end else if (phase_q == 2'd2) begin
          phase_d      = 2'd0;
          pixel_data_d = {sh_q[15:0], gmii_rxd};
          pixel_de_d   = 1'b1;
          pix_cnt_d    = pix_cnt_q + 16'd1;
          if (pix_cnt_q + 16'd1 == pix_total_q) begin
            line_done_d = 1'b1;
            state_d     = StDrop;
          end
        end else begin
          phase_d = phase_q + 2'd1;
        end
      end
      StDrop: begin
        if (!gmii_rx_dv) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (state_d != state_q) cnt_d = 16'd0;
    drop_cnt_d = (drop_inc && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= 16'd0;
      sh_q          <= 24'd0;
      pix_total_q   <= 16'd0;
      pix_cnt_q     <= 16'd0;
      phase_q       <= 2'd0;
      wait_q        <= 1'b1;
      pixel_data_q  <= 24'd0;
      line_number_q <= 16'd0;
      drop_cnt_q    <= 16'd0;
      pixel_de_q    <= 1'b0;
      line_sync_q   <= 1'b0;
      frame_sync_q  <= 1'b0;
      line_done_q   <= 1'b0;
      line_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sh_q          <= sh_d;
      pix_total_q   <= pix_total_d;
      pix_cnt_q     <= pix_cnt_d;
      phase_q       <= phase_d;
      wait_q        <= wait_d;
      pixel_data_q  <= pixel_data_d;
      line_number_q <= line_number_d;
      drop_cnt_q    <= drop_cnt_d;
      pixel_de_q    <= pixel_de_d;
      line_sync_q   <= line_sync_d;
      frame_sync_q  <= frame_sync_d;
      line_done_q   <= line_done_d;
      line_err_q    <= line_err_d;
    end
  end

  // Outputs are forced low for the whole reset window, not just after the first edge.
  assign pixel_data  = reset ? 24'd0 : pixel_data_q;
  assign pixel_de    = reset ? 1'b0  : pixel_de_q;
  assign line_number = reset ? 16'd0 : line_number_q;
  assign line_sync   = reset ? 1'b0  : line_sync_q;
  assign frame_sync  = reset ? 1'b0  : frame_sync_q;
  assign line_done   = reset ? 1'b0  : line_done_q;
  assign line_err    = reset ? 1'b0  : line_err_q;
  assign drop_cnt    = reset ? 16'd0 : drop_cnt_q;

endmodule

// File: tb/tb_eth_video_line_rx.sv
// Scoreboard bench for eth_video_line_rx: a packet-level reference model queues expected
// line/pixel/error events, a negedge monitor pops and compares them.
module tb_eth_video_line_rx;

  localparam logic [15:0] UdpPort = 16'd8080;
  localparam logic [15:0] MaxPix  = 16'd1920;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  gmii_rxd;
  logic        gmii_rx_dv;
  logic [23:0] pixel_data;
  logic        pixel_de, line_sync, frame_sync, line_done, line_err;
  logic [15:0] line_number, drop_cnt;

  eth_video_line_rx #(.UDP_PORT(UdpPort), .MAX_PIXELS(MaxPix)) dut (
    .clk         (clk),
    .reset       (reset),
    .gmii_rxd    (gmii_rxd),
    .gmii_rx_dv  (gmii_rx_dv),
    .pixel_data  (pixel_data),
    .pixel_de    (pixel_de),
    .line_number (line_number),
    .line_sync   (line_sync),
    .frame_sync  (frame_sync),
    .line_done   (line_done),
    .line_err    (line_err),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {logic [23:0] data; logic done;} pix_t;

  int          n_cmp = 0;
  int          n_fail = 0;
  pix_t        exp_pix[$];
  logic [16:0] exp_sync[$];
  int          exp_err = 0;
  logic [15:0] exp_drop = 16'd0;
  logic [15:0] exp_line = 16'd0;
  logic [7:0]  pkt[$];
  logic [23:0] pix_q[$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void bump();
    if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
  endfunction

  // Reference model: walk the packet by byte offsets and derive the events it must produce.
  function automatic void model_pkt();
    int n = pkt.size();
    int i = 1;
    int hdr, avail, npx, p;
    logic [15:0] ln, cnt;
    logic bad;
    while (i < n && pkt[i] == 8'h55) i++;
    if (i >= n || pkt[i] != 8'hD5) begin
      bump();
      return;
    end
    hdr = i + 1;
    for (int k = 0; k < 46; k++) begin
      if (hdr + k >= n) begin
        bump();
        return;
      end
      bad = 1'b0;
      case (k)
        12: bad = (pkt[hdr+12] != 8'h08);
        13: bad = (pkt[hdr+13] != 8'h00);
        14: bad = (pkt[hdr+14] != 8'h45);
        23: bad = (pkt[hdr+23] != 8'h11);
`ifdef ETH_VIDEO_RX_PORT_FILTER_EN
        37: bad = ({pkt[hdr+36], pkt[hdr+37]} != UdpPort);
`endif
        45: bad = ({pkt[hdr+44], pkt[hdr+45]} == 16'd0) ||
                  ({pkt[hdr+44], pkt[hdr+45]} > MaxPix);
        default: bad = 1'b0;
      endcase
      if (bad) begin
        bump();
        return;
      end
    end
    ln  = {pkt[hdr+42], pkt[hdr+43]};
    cnt = {pkt[hdr+44], pkt[hdr+45]};
    exp_line = ln;
    exp_sync.push_back({ln == 16'd0, ln});
    avail = (n - hdr - 46) / 3;
    npx   = (avail < int'(cnt)) ? avail : int'(cnt);
    for (int j = 0; j < npx; j++) begin
      pix_t e;
      p = hdr + 46 + 3 * j;
      e.data = {pkt[p], pkt[p+1], pkt[p+2]};
      e.done = (j == int'(cnt) - 1);
      exp_pix.push_back(e);
    end
    if (avail < int'(cnt)) begin
      exp_err++;
      bump();
    end
  endfunction

  function automatic void build(input logic [15:0] ln, input logic [15:0] cnt,
                                input logic [15:0] etype, input logic [15:0] port,
                                input logic [7:0] ver, input logic [7:0] proto);
    pkt.delete();
    repeat (7) pkt.push_back(8'h55);
    pkt.push_back(8'hD5);
    repeat (12) pkt.push_back(8'($urandom));
    pkt.push_back(etype[15:8]); pkt.push_back(etype[7:0]);
    pkt.push_back(ver);
    repeat (8) pkt.push_back(8'($urandom));
    pkt.push_back(proto);
    repeat (10) pkt.push_back(8'($urandom));
    repeat (2) pkt.push_back(8'($urandom));
    pkt.push_back(port[15:8]); pkt.push_back(port[7:0]);
    repeat (4) pkt.push_back(8'($urandom));
    pkt.push_back(ln[15:8]); pkt.push_back(ln[7:0]);
    pkt.push_back(cnt[15:8]); pkt.push_back(cnt[7:0]);
    foreach (pix_q[j]) begin
      pkt.push_back(pix_q[j][23:16]); pkt.push_back(pix_q[j][15:8]);
      pkt.push_back(pix_q[j][7:0]);
    end
    repeat (4) pkt.push_back(8'($urandom));
  endfunction

  function automatic void gen_pix(input int n);
    pix_q.delete();
    repeat (n) pix_q.push_back(24'($urandom));
  endfunction

  function automatic void trunc(input int len);
    while (pkt.size() > len) void'(pkt.pop_back());
  endfunction

  task automatic drive(input logic [7:0] b);
    @(posedge clk);
    #1 gmii_rxd = b;
    gmii_rx_dv = 1'b1;
  endtask

  task automatic send(input int gap);
    model_pkt();
    foreach (pkt[i]) drive(pkt[i]);
    @(posedge clk);
    #1 gmii_rx_dv = 1'b0;
    gmii_rxd = 8'h00;
    repeat (gap) @(posedge clk);
  endtask

  task automatic drain_check(input string tag);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check({tag, "_drop_cnt"}, drop_cnt, exp_drop);
    check({tag, "_line_number"}, line_number, exp_line);
    check({tag, "_pix_left"}, exp_pix.size(), 0);
    check({tag, "_sync_left"}, exp_sync.size(), 0);
    check({tag, "_err_left"}, exp_err, 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pixel_data"}, pixel_data, 0);
    check({tag, "_line_number"}, line_number, 0);
    check({tag, "_drop_cnt"}, drop_cnt, 0);
    check({tag, "_strobes"}, {pixel_de, line_sync, frame_sync, line_done, line_err}, 0);
  endtask

  always @(negedge clk) begin
    pix_t e;
    logic [16:0] s;
    if (!reset) begin
      if (pixel_de) begin
        if (exp_pix.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL pixel_unexpected: got %h expected none", pixel_data);
        end else begin
          e = exp_pix.pop_front();
          check("pixel_data", pixel_data, e.data);
          check("line_done", line_done, e.done);
        end
      end else if (line_done) begin
        n_cmp++; n_fail++;
        $display("FAIL line_done_alone: got 1 expected 0");
      end
      if (line_sync) begin
        if (exp_sync.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL line_sync_unexpected: got line %0d expected none", line_number);
        end else begin
          s = exp_sync.pop_front();
          check("sync_line_number", line_number, s[15:0]);
          check("frame_sync", frame_sync, s[16]);
        end
      end else if (frame_sync) begin
        n_cmp++; n_fail++;
        $display("FAIL frame_sync_alone: got 1 expected 0");
      end
      if (line_err) begin
        n_cmp++;
        if (exp_err == 0) begin
          n_fail++;
          $display("FAIL line_err_unexpected: got 1 expected 0");
        end else begin
          exp_err--;
        end
      end
    end
  end

  initial begin
    int kind, np;
    logic [15:0] cnt, port, etype;
    logic [7:0]  ver, proto;
    reset = 1'b1; gmii_rx_dv = 1'b0; gmii_rxd = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);

    pix_q.delete();
    pix_q.push_back(24'h112233); pix_q.push_back(24'h445566); pix_q.push_back(24'h778899);
    build(16'd5, 16'd3, 16'h0800, 16'd8080, 8'h45, 8'h11); send(3);
    drain_check("basic");
    build(16'd0, 16'd3, 16'h0800, 16'd8080, 8'h45, 8'h11); send(3);
    build(16'd7, 16'd3, 16'h0806, 16'd8080, 8'h45, 8'h11); send(3);
    drain_check("frame0_arp");

    gen_pix(4);
    build(16'd9, 16'd4, 16'h0800, 16'd8080, 8'h45, 8'h11); trunc(54 + 7); send(3);
    drain_check("trunc");

    gen_pix(2);
    build(16'd3, 16'd0, 16'h0800, 16'd8080, 8'h45, 8'h11); send(2);
    build(16'd4, MaxPix + 16'd1, 16'h0800, 16'd8080, 8'h45, 8'h11); send(2);
    gen_pix(2);
    build(16'd20, 16'd2, 16'h0800, 16'd8080, 8'h45, 8'h11); send(0);
    build(16'd21, 16'd2, 16'h0800, 16'd8080, 8'h45, 8'h11); send(0);
    drain_check("count_bounds_b2b");

    gen_pix(int'(MaxPix));
    build(16'd1079, MaxPix, 16'h0800, 16'd8080, 8'h45, 8'h11); send(2);
    gen_pix(3);
    build(16'd30, 16'd3, 16'h0800, 16'd9000, 8'h45, 8'h11); send(2);
    drain_check("maxpix_port");

    for (int it = 0; it < 40; it++) begin
      np = $urandom_range(1, 6);
      gen_pix(np);
      cnt = 16'($urandom_range(1, np));
      etype = 16'h0800; port = UdpPort; ver = 8'h45; proto = 8'h11;
      kind = $urandom_range(0, 7);
      case (kind)
        1: etype = 16'($urandom);
        2: ver = 8'($urandom);
        3: proto = 8'($urandom);
        4: cnt = ($urandom_range(0, 1) == 0) ? 16'd0 : MaxPix + 16'($urandom_range(1, 50));
        6: port = 16'($urandom);
        default: ;
      endcase
      build(16'($urandom), cnt, etype, port, ver, proto);
      if (kind == 5) trunc($urandom_range(1, pkt.size() - 1));
      if (kind == 7) pkt[$urandom_range(1, 6)] = 8'($urandom);
      send($urandom_range(0, 3));
    end
    drain_check("random");

    // Reset in the middle of a line: one pixel out, then abort with no further events.
    gen_pix(4);
    build(16'd12, 16'd4, 16'h0800, 16'd8080, 8'h45, 8'h11);
    exp_sync.push_back({1'b0, 16'd12});
    exp_pix.push_back('{data: pix_q[0], done: 1'b0});
    for (int i = 0; i < 58; i++) drive(pkt[i]);
    @(posedge clk); #1 reset = 1'b1; gmii_rxd = pkt[58];
    @(negedge clk);
    check_zero("midreset");
    drive(pkt[59]); drive(pkt[60]);
    #1 reset = 1'b0;
    exp_drop = 16'd0; exp_line = 16'd0;
    drive(8'h55); drive(8'h55); drive(8'hD5); drive(8'h55);
    @(posedge clk); #1 gmii_rx_dv = 1'b0;
    build(16'd13, 16'd4, 16'h0800, 16'd8080, 8'h45, 8'h11); send(2);
    drain_check("after_reset");

    for (int i = 0; i < 65539; i++) begin
      pkt.delete();
      pkt.push_back(8'h55);
      send(0);
    end
    drain_check("saturate");
    check("saturate_ffff", drop_cnt, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
